// File: rtl/calc_pkg.sv
// calc_pkg: shared key-entry states, default key codes and key classification
package calc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HAVE_A,
      WAIT_B,
      HAVE_B,
      EXEC,
      SHOW
   } key_state_t;

   localparam logic [3:0] KEY_PLUS = 4'hA;
   localparam logic [3:0] KEY_EQ   = 4'hB;
   localparam logic [3:0] KEY_CLR  = 4'hC;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/bcd_key_sequencer.sv
// bcd_key_sequencer: collects A + B key entry, drives the BCD adder and latches its sum for display
module bcd_key_sequencer
   import calc_pkg::*;
#(
   parameter logic [3:0] KEY_PLUS = calc_pkg::KEY_PLUS,
   parameter logic [3:0] KEY_EQ   = calc_pkg::KEY_EQ,
   parameter logic [3:0] KEY_CLR  = calc_pkg::KEY_CLR
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] KeyCode,
   input  logic       KeyValid,
   output logic       KeyReady,
   output logic [3:0] OpA,
   output logic [3:0] OpB,
   output logic       Add,
   input  logic [3:0] Result,
   input  logic       Carry,
   output logic [3:0] DispTens,
   output logic [3:0] DispOnes,
   output logic       DispValid,
   output logic       Error
);

   key_state_t state, n_state;
   logic [3:0] n_opa, n_opb, n_tens, n_ones;
   logic       n_add, n_valid, n_err;
   logic       key_fire, digit, plus, eq, clr, illegal;

   assign KeyReady = (state != EXEC);
   assign key_fire = KeyValid && KeyReady;
   assign digit    = is_digit(KeyCode);
   assign plus     = (KeyCode == KEY_PLUS);
   assign eq       = (KeyCode == KEY_EQ);
   assign clr      = (KeyCode == KEY_CLR);
   assign illegal  = !digit && !plus && !eq && !clr;

   // Next state and next register values: EXEC always captures the adder, otherwise decode the accepted key
   always_comb begin
      n_state = state;
      n_opa   = OpA;
      n_opb   = OpB;
      n_add   = 1'b0;
      n_tens  = DispTens;
      n_ones  = DispOnes;
      n_valid = DispValid;
      n_err   = Error;
      if (state == EXEC) begin
         n_ones  = Result;
         n_tens  = {3'b000, Carry};
         n_valid = 1'b1;
         n_state = SHOW;
      end else if (key_fire) begin
         if (clr) begin
            n_state = IDLE;
            n_opa   = 4'd0;
            n_opb   = 4'd0;
            n_tens  = 4'd0;
            n_ones  = 4'd0;
            n_valid = 1'b0;
            n_err   = 1'b0;
         end else if (illegal) begin
            n_err = 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (digit) begin
                     n_opa   = KeyCode;
                     n_state = HAVE_A;
                  end else begin
                     n_err = 1'b1;
                  end
               end
               HAVE_A: begin
                  if (digit)     n_opa   = KeyCode;
                  else if (plus) n_state = WAIT_B;
                  else           n_err   = 1'b1;
               end
               WAIT_B: begin
                  if (digit) begin
                     n_opb   = KeyCode;
                     n_state = HAVE_B;
                  end else if (eq) begin
                     n_err = 1'b1;
                  end
               end
               HAVE_B: begin
                  if (digit) begin
                     n_opb = KeyCode;
                  end else if (eq) begin
                     n_add   = 1'b1;
                     n_state = EXEC;
                  end
               end
               SHOW: begin
                  if (digit) begin
                     n_opa   = KeyCode;
                     n_opb   = 4'd0;
                     n_valid = 1'b0;
                     n_state = HAVE_A;
                  end else if (plus) begin
                     n_opa   = DispOnes;
                     n_state = WAIT_B;
                  end else begin
                     n_add   = 1'b1;
                     n_state = EXEC;
                  end
               end
               default: n_state = IDLE;
            endcase
         end
      end
   end

   // State and all output registers; reset overrides an in-flight EXEC capture
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         OpA       <= 4'd0;
         OpB       <= 4'd0;
         Add       <= 1'b0;
         DispTens  <= 4'd0;
         DispOnes  <= 4'd0;
         DispValid <= 1'b0;
         Error     <= 1'b0;
      end else begin
         state     <= n_state;
         OpA       <= n_opa;
         OpB       <= n_opb;
         Add       <= n_add;
         DispTens  <= n_tens;
         DispOnes  <= n_ones;
         DispValid <= n_valid;
         Error     <= n_err;
      end
   end

endmodule

// File: tb/tb_bcd_key_sequencer.sv
// tb_bcd_key_sequencer: directed scenarios plus a randomized key stream against a behavioural calculator model
module tb_bcd_key_sequencer;

   localparam logic [3:0] K_PLUS = 4'hA;
   localparam logic [3:0] K_EQ   = 4'hB;
   localparam logic [3:0] K_CLR  = 4'hC;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] KeyCode = 4'd0;
   logic       KeyValid = 1'b0;
   logic       KeyReady, Add, Carry, DispValid, Error;
   logic [3:0] OpA, OpB, Result, DispTens, DispOnes;
   logic [4:0] sum_raw;
   int         checks = 0;
   int         errors = 0;

   always #5 Clk = ~Clk;

   // Downstream single-digit BCD adder, driven only while Add is high
   assign sum_raw = {1'b0, OpA} + {1'b0, OpB};
   assign Carry   = Add && (sum_raw > 5'd9);
   assign Result  = !Add ? 4'd0 : (sum_raw > 5'd9 ? sum_raw[3:0] + 4'd6 : sum_raw[3:0]);

   bcd_key_sequencer dut (
      .Clk(Clk), .Reset(Reset), .KeyCode(KeyCode), .KeyValid(KeyValid), .KeyReady(KeyReady),
      .OpA(OpA), .OpB(OpB), .Add(Add), .Result(Result), .Carry(Carry),
      .DispTens(DispTens), .DispOnes(DispOnes), .DispValid(DispValid), .Error(Error)
   );

   // Model: phases named by what has been entered, arithmetic sum for the display
   localparam int P_NONE = 0, P_A = 1, P_PLUS = 2, P_B = 3, P_SUM = 4;
   int         mp;
   logic [3:0] ma, mb, mt, mo;
   logic       mv, me;

   task automatic press(input logic [3:0] k);
      @(negedge Clk);
      KeyCode  = k;
      KeyValid = 1'b1;
      @(negedge Clk);
      KeyValid = 1'b0;
   endtask

   task automatic model_clear();
      mp = P_NONE; ma = 0; mb = 0; mt = 0; mo = 0; mv = 0; me = 0;
   endtask

   task automatic model_key(input logic [3:0] k, output bit go);
      go = 0;
      if (k == K_CLR) model_clear();
      else if (k > K_CLR) me = 1;
      else if (k < 4'd10) begin
         if (mp == P_NONE || mp == P_A) begin ma = k; mp = P_A; end
         else if (mp == P_PLUS || mp == P_B) begin mb = k; mp = P_B; end
         else begin ma = k; mb = 0; mv = 0; mp = P_A; end
      end else if (k == K_PLUS) begin
         if (mp == P_NONE) me = 1;
         else if (mp == P_A) mp = P_PLUS;
         else if (mp == P_SUM) begin ma = mo; mp = P_PLUS; end
      end else begin
         if (mp == P_B || mp == P_SUM) go = 1;
         else me = 1;
      end
   endtask

   task automatic model_exec();
      int s;
      s  = int'(ma) + int'(mb);
      mt = 4'(s / 10);
      mo = 4'(s % 10);
      mv = 1;
      mp = P_SUM;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      KeyValid = 1'b0;
      repeat (2) @(negedge Clk);
      checks++;
      if ({OpA, OpB, DispTens, DispOnes, DispValid, Error, Add, KeyReady} !== 20'h00001) begin
         errors++;
         $display("FAIL reset_state: got %h want 00001", {OpA, OpB, DispTens, DispOnes, DispValid, Error, Add, KeyReady});
      end
      Reset = 1'b0;
   endtask

   task automatic test_basic_add();
      press(4'd3); press(K_PLUS); press(4'd4); press(K_EQ);
      checks++;
      if (Add !== 1'b1 || KeyReady !== 1'b0 || DispValid !== 1'b0) begin
         errors++;
         $display("FAIL basic_exec: Add=%b KeyReady=%b DispValid=%b want 1 0 0", Add, KeyReady, DispValid);
      end
      @(negedge Clk);
      checks++;
      if ({Add, DispTens, DispOnes, DispValid} !== {1'b0, 4'd0, 4'd7, 1'b1}) begin
         errors++;
         $display("FAIL basic_sum: Add=%b disp=%0d/%0d valid=%b want 0 0/7 1", Add, DispTens, DispOnes, DispValid);
      end
   endtask

   task automatic test_carry();
      press(K_CLR); press(4'd9); press(K_PLUS); press(4'd8); press(K_EQ);
      @(negedge Clk);
      checks++;
      if ({DispTens, DispOnes, DispValid} !== {4'd1, 4'd7, 1'b1}) begin
         errors++;
         $display("FAIL carry_sum: disp=%0d/%0d valid=%b want 1/7 1", DispTens, DispOnes, DispValid);
      end
   endtask

   task automatic test_overwrite_chain();
      press(K_CLR); press(4'd2); press(4'd5);
      checks++;
      if (OpA !== 4'd5) begin
         errors++;
         $display("FAIL overwrite_opa: got %0d want 5", OpA);
      end
      press(K_PLUS); press(4'd1); press(K_EQ);
      @(negedge Clk);
      checks++;
      if ({DispTens, DispOnes} !== {4'd0, 4'd6}) begin
         errors++;
         $display("FAIL overwrite_sum: disp=%0d/%0d want 0/6", DispTens, DispOnes);
      end
      press(K_PLUS);
      checks++;
      if (OpA !== 4'd6) begin
         errors++;
         $display("FAIL chain_opa: got %0d want 6", OpA);
      end
      press(4'd3); press(K_EQ);
      @(negedge Clk);
      checks++;
      if ({DispTens, DispOnes, DispValid} !== {4'd0, 4'd9, 1'b1}) begin
         errors++;
         $display("FAIL chain_sum: disp=%0d/%0d valid=%b want 0/9 1", DispTens, DispOnes, DispValid);
      end
   endtask

   task automatic test_errors();
      press(K_CLR); press(K_EQ);
      checks++;
      if (Error !== 1'b1 || OpA !== 4'd0 || Add !== 1'b0) begin
         errors++;
         $display("FAIL err_eq_idle: Error=%b OpA=%0d Add=%b want 1 0 0", Error, OpA, Add);
      end
      press(4'd4);
      checks++;
      if (Error !== 1'b1 || OpA !== 4'd4) begin
         errors++;
         $display("FAIL err_sticky: Error=%b OpA=%0d want 1 4", Error, OpA);
      end
      press(K_PLUS); press(4'hE);
      checks++;
      if (Error !== 1'b1 || OpB !== 4'd0) begin
         errors++;
         $display("FAIL err_illegal_waitb: Error=%b OpB=%0d want 1 0", Error, OpB);
      end
      press(4'd2);
      checks++;
      if (OpB !== 4'd2) begin
         errors++;
         $display("FAIL err_state_kept: OpB=%0d want 2", OpB);
      end
      press(K_CLR);
      checks++;
      if ({OpA, OpB, DispTens, DispOnes, DispValid, Error, Add, KeyReady} !== 20'h00001) begin
         errors++;
         $display("FAIL err_clear: got %h want 00001", {OpA, OpB, DispTens, DispOnes, DispValid, Error, Add, KeyReady});
      end
   endtask

   task automatic test_back_to_back();
      press(K_CLR); press(4'd6); press(K_PLUS); press(4'd5);
      @(negedge Clk);
      KeyCode  = K_EQ;
      KeyValid = 1'b1;
      @(negedge Clk);
      checks++;
      if (KeyReady !== 1'b0 || Add !== 1'b1) begin
         errors++;
         $display("FAIL hs_exec: KeyReady=%b Add=%b want 0 1", KeyReady, Add);
      end
      @(negedge Clk);
      checks++;
      if ({KeyReady, Add, DispTens, DispOnes, DispValid} !== {1'b1, 1'b0, 4'd1, 4'd1, 1'b1}) begin
         errors++;
         $display("FAIL hs_show: rdy=%b add=%b disp=%0d/%0d valid=%b want 1 0 1/1 1", KeyReady, Add, DispTens, DispOnes, DispValid);
      end
      @(negedge Clk);
      KeyValid = 1'b0;
      checks++;
      if ({KeyReady, Add, OpA, OpB} !== {1'b0, 1'b1, 4'd6, 4'd5}) begin
         errors++;
         $display("FAIL hs_repeat: rdy=%b add=%b OpA=%0d OpB=%0d want 0 1 6 5", KeyReady, Add, OpA, OpB);
      end
      @(negedge Clk);
      checks++;
      if ({Add, DispTens, DispOnes, Error} !== {1'b0, 4'd1, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL hs_repeat_sum: add=%b disp=%0d/%0d err=%b want 0 1/1 0", Add, DispTens, DispOnes, Error);
      end
   endtask

   task automatic test_reset_exec();
      press(K_CLR); press(4'd5); press(K_PLUS); press(4'd2); press(K_EQ);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      checks++;
      if ({DispValid, Add, KeyReady, DispOnes, OpA} !== {1'b0, 1'b0, 1'b1, 4'd0, 4'd0}) begin
         errors++;
         $display("FAIL reset_exec: valid=%b add=%b rdy=%b ones=%0d OpA=%0d want 0 0 1 0 0", DispValid, Add, KeyReady, DispOnes, OpA);
      end
   endtask

   task automatic test_random();
      bit go;
      logic [3:0] k;
      logic [19:0] exp;
      int r;
      press(K_CLR);
      model_clear();
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 19));
         k = r < 16 ? 4'(r) : (r < 18 ? K_PLUS : K_EQ);
         press(k);
         model_key(k, go);
         exp = {ma, mb, mt, mo, mv, me, go, !go};
         checks++;
         if ({OpA, OpB, DispTens, DispOnes, DispValid, Error, Add, KeyReady} !== exp) begin
            errors++;
            $display("FAIL random_key[%0d] key=%h: got %h want %h", i, k, {OpA, OpB, DispTens, DispOnes, DispValid, Error, Add, KeyReady}, exp);
         end
         if (go) begin
            @(negedge Clk);
            model_exec();
            exp = {ma, mb, mt, mo, mv, me, 1'b0, 1'b1};
            checks++;
            if ({OpA, OpB, DispTens, DispOnes, DispValid, Error, Add, KeyReady} !== exp) begin
               errors++;
               $display("FAIL random_sum[%0d]: got %h want %h", i, {OpA, OpB, DispTens, DispOnes, DispValid, Error, Add, KeyReady}, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_carry();
      test_overwrite_chain();
      test_errors();
      test_back_to_back();
      test_reset_exec();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
